// File: rtl/parkclarke_axis.sv
// parkclarke_axis: four-stage Clarke + Park transform with AXI-Stream handshake.
// Input beat {rsvd, theta, ib, ia} -> output beat {0, theta, q, d}.
// Build option PARKCLARKE_SAT_EN: beta, d and q saturate to the DATA_W range
// instead of wrapping to the low DATA_W bits.
module parkclarke_axis #(
  parameter int DATA_W = 16,
  parameter int LUT_AW = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4*DATA_W-1:0] s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_last,
  output logic [4*DATA_W-1:0] m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_last
);

  // Accumulator width: (ia + 2*ib) * K and the sum of two products both fit.
  localparam int  WA    = 2*DATA_W + 3;
  localparam int  LUT_N = 1 << LUT_AW;
  localparam real PI_R  = 3.14159265358979323846;

  // K = round(2^(DATA_W-1)/sqrt(3)): largest k with 3*(2k-1)^2 <= 2^(2*DATA_W).
  function automatic longint clarke_k();
    longint lo, hi, mid, lim;
    lim = longint'(1) <<< (2*DATA_W);
    lo  = 1;
    hi  = longint'(1) <<< (DATA_W-1);
    while (lo < hi) begin
      mid = (lo + hi + 1) >>> 1;
      if (3 * (2*mid - 1) * (2*mid - 1) <= lim) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  // Quarter-wave entry i = round((2^(DATA_W-1)-1) * sin(i*pi/2^(LUT_AW+1))).
  function automatic logic signed [DATA_W-1:0] sin_entry(input int i);
    real amp, ph;
    amp = real'((longint'(1) <<< (DATA_W-1)) - 1);
    if (i >= LUT_N) return DATA_W'((longint'(1) <<< (DATA_W-1)) - 1);
    ph = PI_R * real'(i) / real'(2*LUT_N);
    return DATA_W'($rtoi($floor(amp * $sin(ph) + 0.5)));
  endfunction

  localparam logic signed [WA-1:0] K_WA     = WA'(clarke_k());
  localparam logic signed [WA-1:0] RND_HALF = WA'(longint'(1) <<< (DATA_W-2));
`ifdef PARKCLARKE_SAT_EN
  localparam logic signed [WA-1:0] SAT_MAX  = WA'((longint'(1) <<< (DATA_W-1)) - 1);
  localparam logic signed [WA-1:0] SAT_MIN  = WA'(-(longint'(1) <<< (DATA_W-1)));
`endif

  // Round half up: add 2^(DATA_W-2), arithmetic shift right by DATA_W-1.
  function automatic logic signed [WA-1:0] round_half_up(input logic signed [WA-1:0] v);
    return (v + RND_HALF) >>> (DATA_W-1);
  endfunction

  // Reduce a rounded value to DATA_W bits (clamp or two's-complement wrap).
  function automatic logic signed [DATA_W-1:0] narrow(input logic signed [WA-1:0] v);
`ifdef PARKCLARKE_SAT_EN
    if (v > SAT_MAX) return DATA_W'(SAT_MAX);
    else if (v < SAT_MIN) return DATA_W'(SAT_MIN);
    else return DATA_W'(v);
`else
    return DATA_W'(v);
`endif
  endfunction

  logic signed [DATA_W-1:0] sin_lut [0:LUT_N];
  for (genvar gi = 0; gi <= LUT_N; gi++) begin : g_lut
    assign sin_lut[gi] = sin_entry(gi);
  end

  logic unused_rsvd;
  assign unused_rsvd = ^s_axis_tdata[4*DATA_W-1:3*DATA_W];

  // Whole pipeline moves together unless the output slot is full and blocked.
  logic advance;
  assign advance       = !(m_axis_tvalid && !m_axis_tready);
  assign s_axis_tready = advance && reset;

  logic                     vld_p1, vld_p2, vld_p3;
  logic signed [DATA_W-1:0] ia_p1, ib_p1;
  logic        [DATA_W-1:0] theta_p1, theta_p2, theta_p3;
  logic        [1:0]        quad_p1;
  logic        [LUT_AW-1:0] addr_p1;
  logic                     last_p1, last_p2, last_p3;
  logic signed [DATA_W-1:0] alpha_p2, beta_p2, sin_p2, cos_p2;
  logic signed [2*DATA_W-1:0] ac_p3, bs_p3, bc_p3, as_p3;

  // Valid bits shift with the pipeline and are cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1        <= 1'b0;
      vld_p2        <= 1'b0;
      vld_p3        <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else if (advance) begin
      vld_p1        <= s_axis_tvalid;
      vld_p2        <= vld_p1;
      vld_p3        <= vld_p2;
      m_axis_tvalid <= vld_p3;
    end
  end

  // ---- S1: capture fields, split theta into quadrant and table address ----
  always_ff @(posedge clk) begin
    if (advance) begin
      ia_p1    <= s_axis_tdata[DATA_W-1:0];
      ib_p1    <= s_axis_tdata[2*DATA_W-1:DATA_W];
      theta_p1 <= s_axis_tdata[3*DATA_W-1:2*DATA_W];
      quad_p1  <= s_axis_tdata[3*DATA_W-1 -: 2];
      addr_p1  <= s_axis_tdata[3*DATA_W-3 -: LUT_AW];
      last_p1  <= s_last;
    end
  end

  logic signed [DATA_W+1:0] clarke_sum;
  logic signed [WA-1:0]     beta_prod;
  logic        [LUT_AW:0]   idx_fwd, idx_rev;
  logic signed [DATA_W-1:0] tab_fwd, tab_rev, sin_v, cos_v;

  assign clarke_sum = (DATA_W+2)'(ia_p1) + ((DATA_W+2)'(ib_p1) <<< 1);
  assign beta_prod  = WA'(clarke_sum) * K_WA;
  assign idx_fwd    = {1'b0, addr_p1};
  assign idx_rev    = (LUT_AW+1)'(LUT_N) - idx_fwd;
  assign tab_fwd    = sin_lut[idx_fwd];
  assign tab_rev    = sin_lut[idx_rev];

  // Mirror and negate the quarter table; cos is sin advanced by one quadrant.
  always_comb begin
    sin_v = tab_fwd;
    cos_v = tab_rev;
    unique case (quad_p1)
      2'd0: begin sin_v = tab_fwd;  cos_v = tab_rev;  end
      2'd1: begin sin_v = tab_rev;  cos_v = -tab_fwd; end
      2'd2: begin sin_v = -tab_fwd; cos_v = -tab_rev; end
      default: begin sin_v = -tab_rev; cos_v = tab_fwd; end
    endcase
  end

  // ---- S2: alpha, rounded beta, sin/cos ----
  always_ff @(posedge clk) begin
    if (advance) begin
      alpha_p2 <= ia_p1;
      beta_p2  <= narrow(round_half_up(beta_prod));
      sin_p2   <= sin_v;
      cos_p2   <= cos_v;
      theta_p2 <= theta_p1;
      last_p2  <= last_p1;
    end
  end

  // ---- S3: four full-width products ----
  always_ff @(posedge clk) begin
    if (advance) begin
      ac_p3    <= (2*DATA_W)'(alpha_p2) * (2*DATA_W)'(cos_p2);
      bs_p3    <= (2*DATA_W)'(beta_p2)  * (2*DATA_W)'(sin_p2);
      bc_p3    <= (2*DATA_W)'(beta_p2)  * (2*DATA_W)'(cos_p2);
      as_p3    <= (2*DATA_W)'(alpha_p2) * (2*DATA_W)'(sin_p2);
      theta_p3 <= theta_p2;
      last_p3  <= last_p2;
    end
  end

  logic signed [DATA_W-1:0] d_v, q_v;
  assign d_v = narrow(round_half_up(WA'(ac_p3) + WA'(bs_p3)));
  assign q_v = narrow(round_half_up(WA'(bc_p3) - WA'(as_p3)));

  // ---- S4: output register, loaded only by valid beats so bubbles hold data ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_axis_tdata <= '0;
      m_last       <= 1'b0;
    end else if (advance && vld_p3) begin
      m_axis_tdata <= {{DATA_W{1'b0}}, theta_p3, q_v, d_v};
      m_last       <= last_p3;
    end
  end

endmodule

// File: tb/tb_parkclarke_axis.sv
// tb_parkclarke_axis: scoreboard bench for parkclarke_axis (DATA_W=16, LUT_AW=8).
module tb_parkclarke_axis;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_last;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_last;

  parkclarke_axis #(.DATA_W(16), .LUT_AW(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_last        (s_last),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_last        (m_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [15:0] q;
    logic [15:0] th;
    logic        last;
    bit          lat;
    longint      acc_edge;
  } exp_t;

  exp_t   q_exp[$];
  int     tests = 0;
  int     fails = 0;
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference arithmetic on plain integers and reals.
  function automatic longint rnd15(input longint v);
    return (v + 16384) >>> 15;
  endfunction

  function automatic longint narrow16(input longint v);
    logic [15:0] t;
`ifdef PARKCLARKE_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    t = v[15:0];
    return longint'($signed(t));
`endif
  endfunction

  function automatic longint sround(input real x);
    if (x >= 0.0) return longint'($rtoi($floor(x + 0.5)));
    return -longint'($rtoi($floor(-x + 0.5)));
  endfunction

  function automatic exp_t model(input logic [15:0] ia, input logic [15:0] ib,
                                 input logic [15:0] th, input bit last);
    exp_t   e;
    longint a, b, k, beta, sn, cs, dd, qq;
    int     idx;
    real    ang;
    a    = longint'($signed(ia));
    b    = longint'($signed(ib));
    k    = longint'($rtoi($floor(32768.0 / $sqrt(3.0) + 0.5)));
    beta = narrow16(rnd15((a + 2*b) * k));
    idx  = int'(th >> 6);
    ang  = 2.0 * 3.14159265358979323846 * real'(idx) / 1024.0;
    sn   = sround(32767.0 * $sin(ang));
    cs   = sround(32767.0 * $cos(ang));
    dd   = narrow16(rnd15(a*cs + beta*sn));
    qq   = narrow16(rnd15(beta*cs - a*sn));
    e.d = 16'(dd); e.q = 16'(qq); e.th = th; e.last = last;
    e.lat = 1'b0; e.acc_edge = 0;
    return e;
  endfunction

  // One cycle of stimulus; pushes the expected result when the beat is taken.
  task automatic drive(input bit v, input logic [15:0] ia, input logic [15:0] ib,
                       input logic [15:0] th, input bit last, input bit rdy,
                       input bit use_k, input logic [15:0] kd, input logic [15:0] kq,
                       input bit lat, output bit acc);
    exp_t e;
    @(negedge clk);
    s_axis_tvalid = v;
    s_axis_tdata  = {16'($urandom), th, ib, ia};
    s_last        = last;
    m_axis_tready = rdy;
    #1;
    acc = v && s_axis_tready;
    if (acc) begin
      e = model(ia, ib, th, last);
      if (use_k) begin e.d = kd; e.q = kq; end
      e.lat = lat;
      e.acc_edge = cyc + 1;
      q_exp.push_back(e);
    end
  endtask

  task automatic send(input logic [15:0] ia, input logic [15:0] ib, input logic [15:0] th,
                      input bit last, input bit use_k, input logic [15:0] kd,
                      input logic [15:0] kq, input bit lat);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 100) begin
      drive(1'b1, ia, ib, th, last, 1'b1, use_k, kd, kq, lat, acc);
      n++;
    end
    tests++;
    if (!acc) begin
      fails++;
      $display("FAIL accept_timeout: beat ia=%h not taken in %0d cycles, required taken", ia, n);
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    bit acc;
    for (int i = 0; i < n; i++)
      drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, rdy, 1'b0, 16'h0, 16'h0, 1'b0, acc);
  endtask

  task automatic check_empty(input string tag);
    tests++;
    if (q_exp.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d expected beats outstanding, required 0", tag, q_exp.size());
    end
  endtask

  // Monitor: pops and compares on every output handshake; checks stall behaviour.
  initial begin : monitor
    exp_t        e;
    bit          prev_stall;
    logic [63:0] prev_data;
    logic        prev_last;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (reset !== 1'b1) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          tests++;
          if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data || m_last !== prev_last) begin
            fails++;
            $display("FAIL stall_hold: got v=%b data=%h last=%b, required v=1 data=%h last=%b",
                     m_axis_tvalid, m_axis_tdata, m_last, prev_data, prev_last);
          end
        end
        if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b0) begin
          tests++;
          if (s_axis_tready !== 1'b0) begin
            fails++;
            $display("FAIL stall_sready: s_axis_tready=%b, required 0", s_axis_tready);
          end
          prev_stall = 1'b1;
          prev_data  = m_axis_tdata;
          prev_last  = m_last;
        end else begin
          prev_stall = 1'b0;
        end
        if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
          tests++;
          if (q_exp.size() == 0) begin
            fails++;
            $display("FAIL unexpected_beat: got data=%h last=%b, required no beat",
                     m_axis_tdata, m_last);
          end else begin
            e = q_exp.pop_front();
            if (m_axis_tdata !== {16'h0, e.th, e.q, e.d} || m_last !== e.last) begin
              fails++;
              $display("FAIL beat_data: got data=%h last=%b, required data=%h last=%b",
                       m_axis_tdata, m_last, {16'h0, e.th, e.q, e.d}, e.last);
            end
            if (e.lat) begin
              tests++;
              if (cyc - e.acc_edge != 3) begin
                fails++;
                $display("FAIL latency: got output %0d edges after accept edge, required 3",
                         cyc - e.acc_edge);
              end
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit acc;
    int b;
    int c;
    reset         = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 64'h0000_0000_FDA8_0064;
    s_last        = 1'b1;
    m_axis_tready = 1'b1;

    // Reset state with an input beat being offered.
    repeat (3) begin
      @(negedge clk);
      #1;
      tests++;
      if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 64'h0 || m_last !== 1'b0) begin
        fails++;
        $display("FAIL reset_out: got v=%b data=%h last=%b, required 0/0/0",
                 m_axis_tvalid, m_axis_tdata, m_last);
      end
      tests++;
      if (s_axis_tready !== 1'b0) begin
        fails++;
        $display("FAIL reset_sready: s_axis_tready=%b, required 0", s_axis_tready);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    s_axis_tvalid = 1'b0;
    s_last = 1'b0;

    // Directed beats with known results.
    send(16'd100, 16'hFDA8, 16'h0000, 1'b0, 1'b1, 16'h0064, 16'hFD85, 1'b1);
    idle(6, 1'b1);
    send(16'd100, 16'hFDA8, 16'h4000, 1'b0, 1'b1, 16'hFD85, 16'hFF9C, 1'b1);
    idle(6, 1'b1);
`ifdef PARKCLARKE_SAT_EN
    send(16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h7FFE, 16'h7FFE, 1'b1);
`else
    send(16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h7FFE, 16'hDDB3, 1'b1);
`endif
    idle(6, 1'b1);
    check_empty("directed_drain");

    // Back-pressure burst: ia=1..8, last on beat 5, ready low for 3 cycles.
    b = 0;
    c = 0;
    while (b < 8 && c < 100) begin
      drive(1'b1, 16'(b + 1), 16'h0, 16'h0, (b == 4), !(c >= 5 && c < 8),
            1'b1, 16'(b + 1), model(16'(b + 1), 16'h0, 16'h0, 1'b0).q, 1'b0, acc);
      if (acc) b++;
      c++;
    end
    tests++;
    if (b != 8) begin
      fails++;
      $display("FAIL burst_accept: %0d beats taken, required 8", b);
    end
    idle(10, 1'b1);
    check_empty("burst_drain");

    // Reset with three beats in flight, the first one stalled at the output.
    send(16'h0011, 16'h0022, 16'h1000, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    send(16'h0033, 16'h0044, 16'h2000, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    send(16'h0055, 16'h0066, 16'h3000, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    idle(2, 1'b0);
    #2;
    tests++;
    if (m_axis_tvalid !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_valid: m_axis_tvalid=%b, required 1", m_axis_tvalid);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (m_axis_tvalid !== 1'b0 || m_last !== 1'b0 || m_axis_tdata !== 64'h0) begin
      fails++;
      $display("FAIL async_reset: got v=%b last=%b data=%h, required 0/0/0",
               m_axis_tvalid, m_last, m_axis_tdata);
    end
    tests++;
    if (s_axis_tready !== 1'b0) begin
      fails++;
      $display("FAIL async_reset_sready: s_axis_tready=%b, required 0", s_axis_tready);
    end
    q_exp.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle(8, 1'b1);
    send(16'hFF38, 16'h00C8, 16'h8000, 1'b1, 1'b0, 16'h0, 16'h0, 1'b1);
    idle(6, 1'b1);
    check_empty("post_reset_drain");

    // Randomised traffic with random valid gaps and back-pressure.
    for (int i = 0; i < 400; i++)
      drive(($urandom % 10) < 7, 16'($urandom), 16'($urandom), 16'($urandom),
            1'($urandom), ($urandom % 4) != 0, 1'b0, 16'h0, 16'h0, 1'b0, acc);
    c = 0;
    while (q_exp.size() != 0 && c < 200) begin
      idle(1, 1'b1);
      c++;
    end
    idle(2, 1'b1);
    check_empty("random_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
